// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush,
// data-memory wait freeze with timeout halt and event counters.
module hazard_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_Rs1_i,
  input  logic [4:0]       ID_Rs2_i,
  input  logic             ID_UsesRs2_i,
  input  logic [4:0]       EX_Rd_i,
  input  logic             EX_MemRead_i,
  input  logic             Branch_i,
  input  logic             MEM_Req_i,
  input  logic             MEM_Ready_i,
  output logic             PCWrite_o,
  output logic             IFID_Write_o,
  output logic             IFID_Flush_o,
  output logic             IDEX_Bubble_o,
  output logic             Freeze_o,
  output logic             Halt_o,
  output logic [1:0]       State_o,
  output logic [CNT_W-1:0] StallCnt_o,
  output logic [CNT_W-1:0] FlushCnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_e;

  localparam logic [7:0]       WLAST = 8'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SAT   = '1;

  state_e           state_q, state_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic memwait;
  logic loaduse;
  logic rs1_hit;
  logic rs2_hit;

  assign memwait = MEM_Req_i & ~MEM_Ready_i;
  assign rs1_hit = (EX_Rd_i == ID_Rs1_i);
  assign rs2_hit = ID_UsesRs2_i & (EX_Rd_i == ID_Rs2_i);
  assign loaduse = EX_MemRead_i & (EX_Rd_i != 5'd0)
                 & (rs1_hit | rs2_hit);

  // Priority: reset > halt > memwait > loaduse > branch.
  always_comb begin
    PCWrite_o     = 1'b1;
    IFID_Write_o  = 1'b1;
    IFID_Flush_o  = 1'b0;
    IDEX_Bubble_o = 1'b0;
    Freeze_o      = 1'b0;
    if (rst_i) begin
      PCWrite_o     = 1'b0;
      IFID_Write_o  = 1'b0;
      IDEX_Bubble_o = 1'b1;
    end else if (state_q == HALT) begin
      PCWrite_o    = 1'b0;
      IFID_Write_o = 1'b0;
      Freeze_o     = 1'b1;
    end else if (memwait) begin
      PCWrite_o    = 1'b0;
      IFID_Write_o = 1'b0;
      Freeze_o     = 1'b1;
    end else if (state_q == RUN && loaduse) begin
      PCWrite_o     = 1'b0;
      IFID_Write_o  = 1'b0;
      IDEX_Bubble_o = 1'b1;
    end else if (state_q == RUN && Branch_i) begin
      IFID_Flush_o = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = 8'd0;
    if (state_q == HALT) begin
      state_d = HALT;
      wcnt_d  = wcnt_q;
    end else if (state_q == MEM_WAIT) begin
      if (!memwait) begin
        state_d = RUN;
      end else begin
        wcnt_d  = wcnt_q + 8'd1;
        state_d = (wcnt_q == WLAST) ? HALT : MEM_WAIT;
      end
    end else begin
      state_d = memwait ? MEM_WAIT : RUN;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!PCWrite_o && stall_q != SAT)
      stall_d = stall_q + ONE;
    if (IFID_Flush_o && flush_q != SAT)
      flush_d = flush_q + ONE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      wcnt_q  <= 8'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign Halt_o     = (state_q == HALT);
  assign State_o    = state_q;
  assign StallCnt_o = stall_q;
  assign FlushCnt_o = flush_q;

endmodule
